// File: rtl/row_addr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : row_addr_sequencer
// Brief    : Steps a one-hot decoder's row index through a programmable run of
//            rows, holding each row for a programmable dwell, with stall and
//            busy/done handshaking.
// Revision : 1.0 - initial release
// ============================================================================
module row_addr_sequencer #(
    parameter int N  = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [N-1:0]  base_addr_i,
    input  logic [N:0]    num_rows_i,
    input  logic [DW-1:0] dwell_i,
    input  logic          stall_i,
    output logic [N-1:0]  addr_o,
    output logic          addr_valid_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [N-1:0]  addr_q,      addr_d;
    logic          valid_q,     valid_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic [N:0]    remaining_q, remaining_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DW-1:0] dwell_q,     dwell_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            dwell_cnt_q <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            dwell_cnt_q <= dwell_cnt_d;
            dwell_q     <= dwell_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        dwell_cnt_d = dwell_cnt_q;
        dwell_d     = dwell_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    dwell_d = dwell_i;
                    if (num_rows_i != '0) begin
                        state_d     = S_RUN;
                        addr_d      = base_addr_i;
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                        dwell_cnt_d = dwell_i;
                        remaining_d = num_rows_i;
                    end else begin
                        // Empty scan still produces a done pulse so the
                        // controller sees a uniform handshake.
                        state_d     = S_DONE;
                        busy_d      = 1'b1;
                        done_d      = 1'b1;
                        remaining_d = '0;
                        dwell_cnt_d = '0;
                    end
                end
            end

            S_RUN: begin
                if (!stall_i) begin
                    if (dwell_cnt_q != '0) begin
                        dwell_cnt_d = dwell_cnt_q - DW'(1);
                    end else if (remaining_q == (N+1)'(1)) begin
                        state_d     = S_DONE;
                        valid_d     = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        // Natural N-bit overflow gives the modulo-2^N wrap.
                        addr_d      = addr_q + N'(1);
                        remaining_d = remaining_q - (N+1)'(1);
                        dwell_cnt_d = dwell_q;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_row_addr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_row_addr_sequencer
// Brief    : Scoreboard bench for row_addr_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_addr_sequencer;

    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [N-1:0]  base = '0;
    logic [N:0]    nrows = '0;
    logic [DW-1:0] dwell = '0;
    logic [N-1:0]  addr;
    logic          valid;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic         v;
        logic [N-1:0] a;
        logic         d;
        logic         b;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [N+2:0] obs_w;
    int         n_pass = 0;
    int         n_total = 0;

    assign obs_w = {valid, addr, done, busy};

    row_addr_sequencer #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .base_addr_i (base),
        .num_rows_i  (nrows),
        .dwell_i     (dwell),
        .stall_i     (stall),
        .addr_o      (addr),
        .addr_valid_o(valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Expected trace of an unstalled scan: each row dwell+1 cycles, then the
    // done cycle and one idle cycle, both holding the last row.
    task automatic push_scan(input logic [N-1:0] b, input int n, input int dw,
                             input logic [N-1:0] prev);
        logic [N-1:0] a;
        a = prev;
        for (int r = 0; r < n; r++) begin
            a = b + N'(r);
            for (int d = 0; d <= dw; d++) sbq.push_back('{1'b1, a, 1'b0, 1'b1});
        end
        sbq.push_back('{1'b0, a, 1'b1, 1'b1});
        sbq.push_back('{1'b0, a, 1'b0, 1'b0});
    endtask

    task automatic test_reset();
        int i;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs_w !== '0) $display("FAIL reset_hold: got %b want %b", obs_w, {(N+3){1'b0}});
        else n_pass++;
        rst = 1'b0;

        base = 4'd7; nrows = 5'd8; dwell = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if (obs_w !== {1'b1, 4'd7, 1'b0, 1'b1}) $display("FAIL run_before_rst: got %b want %b", obs_w, {1'b1, 4'd7, 1'b0, 1'b1});
        else n_pass++;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_total++;
        if (obs_w !== '0) $display("FAIL rst_async: got %b want %b", obs_w, {(N+3){1'b0}});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;

        base = 4'd1; nrows = 5'd2; dwell = 4'd0; start = 1'b1;
        push_scan(4'd1, 2, 0, 4'd0);
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL after_rst cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (i == 0) start = 1'b0;
            i++;
        end
    endtask

    task automatic test_basic();
        int i;
        base = 4'd3; nrows = 5'd4; dwell = 4'd0; start = 1'b1;
        push_scan(4'd3, 4, 0, 4'd2);
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL basic cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (i == 0) start = 1'b0;
            i++;
        end
    endtask

    task automatic test_dwell_wrap();
        int i;
        base = 4'd14; nrows = 5'd4; dwell = 4'd2; start = 1'b1;
        push_scan(4'd14, 4, 2, 4'd6);
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL dwell_wrap cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (i == 0) start = 1'b0;
            i++;
        end
    endtask

    task automatic test_stall();
        int i;
        base = 4'd0; nrows = 5'd2; dwell = 4'd1; start = 1'b1;
        for (int k = 0; k < 5; k++) sbq.push_back('{1'b1, 4'd0, 1'b0, 1'b1});
        for (int k = 0; k < 2; k++) sbq.push_back('{1'b1, 4'd1, 1'b0, 1'b1});
        sbq.push_back('{1'b0, 4'd1, 1'b1, 1'b1});
        sbq.push_back('{1'b0, 4'd1, 1'b0, 1'b0});
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL stall cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (i == 0) start = 1'b0;
            // Stall three RUN edges on row 0, then again across DONE where it must be ignored.
            stall = (i < 3) || (i >= 7);
            i++;
        end
        stall = 1'b0;
    endtask

    task automatic test_zero_rows();
        int i;
        base = 4'd9; nrows = 5'd0; dwell = 4'd3; start = 1'b1;
        sbq.push_back('{1'b0, 4'd1, 1'b1, 1'b1});
        sbq.push_back('{1'b0, 4'd1, 1'b0, 1'b0});
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL zero_rows cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (i == 0) start = 1'b0;
            i++;
        end
    endtask

    task automatic test_full_wrap();
        int i;
        int bad;
        int hits[16];
        logic [15:0] seen;
        logic [15:0] onehot;
        seen = '0;
        for (int k = 0; k < 16; k++) hits[k] = 0;
        base = 4'd5; nrows = 5'd16; dwell = 4'd0; start = 1'b1;
        push_scan(4'd5, 16, 0, 4'd1);
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL full_wrap cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (valid === 1'b1) begin
                onehot = 16'd1 << addr;
                seen = seen | onehot;
                hits[addr]++;
            end
            if (i == 0) start = 1'b0;
            i++;
        end
        bad = 0;
        for (int k = 0; k < 16; k++) if (hits[k] != 1) bad++;
        n_total++;
        if (bad != 0 || seen !== 16'hFFFF) $display("FAIL onehot_cover: got seen=%h bad_rows=%0d want seen=ffff bad_rows=0", seen, bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int i;
        base = 4'd2; nrows = 5'd3; dwell = 4'd0; start = 1'b1;
        push_scan(4'd2, 3, 0, 4'd4);
        push_scan(4'd9, 2, 1, 4'd4);
        i = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk); #1;
            n_total++;
            if (obs_w !== e) $display("FAIL back_to_back cyc%0d: got v=%b a=%0d d=%b b=%b want v=%b a=%0d d=%b b=%b",
                                      i, valid, addr, done, busy, e.v, e.a, e.d, e.b);
            else n_pass++;
            if (i == 0) begin
                base = 4'd9; nrows = 5'd2; dwell = 4'd1;
            end
            if (i == 5) start = 1'b0;
            i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_dwell_wrap();
        test_stall();
        test_zero_rows();
        test_full_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
